// File: rtl/mole_scheduler.sv
// Purpose : whack-a-mole spawn/lifetime scheduler; ticks, LFSR slot pick, hit/miss/escape pulses.
// Latency : every output is registered; an event sampled on a rising edge shows from that edge.
// Backpr. : none; enable=0 freezes all state, clear restarts the round and wins over enable.
// Ports   : clock, reset (async, active low), enable, clear, whackValid/whackIndex in;
//           molesUp, molesHit (one bit per slot), hitPulse, missPulse, escapePulse out.
module mole_scheduler #(
   parameter int NUM_MOLES   = 5,
   parameter int TICK_DIV    = 500000,
   parameter int SPAWN_TICKS = 50,
   parameter int LIFE_TICKS  = 100,
   parameter int HIT_TICKS   = 20
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 clear,
   input  logic                 whackValid,
   input  logic [2:0]           whackIndex,
   output logic [NUM_MOLES-1:0] molesUp,
   output logic [NUM_MOLES-1:0] molesHit,
   output logic                 hitPulse,
   output logic                 missPulse,
   output logic                 escapePulse
);

   localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SPAWN_W = (SPAWN_TICKS > 1) ? $clog2(SPAWN_TICKS) : 1;
   localparam int CNT_MAX = (LIFE_TICKS > HIT_TICKS) ? LIFE_TICKS : HIT_TICKS;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
   localparam logic [SPAWN_W-1:0] SPAWN_LAST = SPAWN_W'(SPAWN_TICKS - 1);
   localparam logic [CNT_W-1:0]   LIFE_LAST  = CNT_W'(LIFE_TICKS - 1);
   localparam logic [CNT_W-1:0]   HIT_LAST   = CNT_W'(HIT_TICKS - 1);

   typedef enum logic [1:0] {
      MOLE_OFF = 2'd0,
      MOLE_UP  = 2'd1,
      MOLE_HIT = 2'd2
   } moleState_t;

   moleState_t             moleState     [NUM_MOLES];
   moleState_t             moleStateNext [NUM_MOLES];
   logic [CNT_W-1:0]       moleCnt       [NUM_MOLES];
   logic [CNT_W-1:0]       moleCntNext   [NUM_MOLES];
   logic [TICK_W-1:0]      tickCnt, tickCntNext;
   logic [SPAWN_W-1:0]     spawnCnt, spawnCntNext;
   logic [7:0]             lfsr, lfsrNext;

   logic                   tick, spawnNow, whackOk, found;
   logic [NUM_MOLES-1:0]   upVec, offVec, whackVec, spawnSel;
   logic [NUM_MOLES-1:0]   upNext, hitNext;
   logic                   hitPulseNext, missPulseNext, escapePulseNext;
   logic [2:0]             startIdx, probe;
   logic [3:0]             probeSum;

   always_comb begin
      tickCntNext     = tickCnt;
      spawnCntNext    = spawnCnt;
      tick            = 1'b0;
      spawnNow        = 1'b0;
      whackOk         = 1'b0;
      found           = 1'b0;
      hitPulseNext    = 1'b0;
      missPulseNext   = 1'b0;
      escapePulseNext = 1'b0;
      upVec           = '0;
      offVec          = '0;
      whackVec        = '0;
      spawnSel        = '0;
      upNext          = '0;
      hitNext         = '0;
      probe           = 3'd0;
      probeSum        = 4'd0;
      // x^8+x^6+x^5+x^4+1, free-running regardless of enable/clear
      lfsrNext        = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      // start slot folds 5..7 back onto 0..2
      startIdx        = (lfsr[2:0] >= 3'd5) ? (lfsr[2:0] - 3'd5) : lfsr[2:0];

      for (int i = 0; i < NUM_MOLES; i++) begin
         moleStateNext[i] = moleState[i];
         moleCntNext[i]   = moleCnt[i];
         upVec[i]         = (moleState[i] == MOLE_UP);
         offVec[i]        = (moleState[i] == MOLE_OFF);
      end

      if (clear) begin
         tickCntNext  = '0;
         spawnCntNext = '0;
         for (int i = 0; i < NUM_MOLES; i++) begin
            moleStateNext[i] = MOLE_OFF;
            moleCntNext[i]   = '0;
         end
      end else if (enable) begin
         tick        = (tickCnt == TICK_LAST);
         tickCntNext = tick ? '0 : tickCnt + TICK_W'(1);
         if (tick) begin
            spawnNow     = (spawnCnt == SPAWN_LAST);
            spawnCntNext = spawnNow ? '0 : spawnCnt + SPAWN_W'(1);
         end

         whackOk = whackValid && (whackIndex < 3'(NUM_MOLES));
         for (int i = 0; i < NUM_MOLES; i++) begin
            whackVec[i] = whackOk && (whackIndex == 3'(i));
         end
         // whacks are judged on the state held before this edge
         hitPulseNext  = |(whackVec & upVec);
         missPulseNext = whackOk && !hitPulseNext;

         // probe s, s+1, ... (mod NUM_MOLES) for the first slot OFF before this edge
         if (spawnNow) begin
            for (int j = 0; j < NUM_MOLES; j++) begin
               probeSum = {1'b0, startIdx} + 4'(j);
               probe    = (probeSum >= 4'(NUM_MOLES)) ? 3'(probeSum - 4'(NUM_MOLES))
                                                      : probeSum[2:0];
               for (int m = 0; m < NUM_MOLES; m++) begin
                  if (!found && offVec[m] && (probe == 3'(m))) begin
                     spawnSel[m] = 1'b1;
                     found       = 1'b1;
                  end
               end
            end
         end

         for (int i = 0; i < NUM_MOLES; i++) begin
            case (moleState[i])
               MOLE_UP: begin
                  // a whack on the final life tick beats the escape
                  if (whackVec[i]) begin
                     moleStateNext[i] = MOLE_HIT;
                     moleCntNext[i]   = '0;
                  end else if (tick) begin
                     if (moleCnt[i] == LIFE_LAST) begin
                        moleStateNext[i] = MOLE_OFF;
                        moleCntNext[i]   = '0;
                        escapePulseNext  = 1'b1;
                     end else begin
                        moleCntNext[i] = moleCnt[i] + CNT_W'(1);
                     end
                  end
               end
               MOLE_HIT: begin
                  if (tick) begin
                     if (moleCnt[i] == HIT_LAST) begin
                        moleStateNext[i] = MOLE_OFF;
                        moleCntNext[i]   = '0;
                     end else begin
                        moleCntNext[i] = moleCnt[i] + CNT_W'(1);
                     end
                  end
               end
               MOLE_OFF: begin
                  if (spawnSel[i]) begin
                     moleStateNext[i] = MOLE_UP;
                     moleCntNext[i]   = '0;
                  end
               end
               default: begin
                  moleStateNext[i] = MOLE_OFF;
                  moleCntNext[i]   = '0;
               end
            endcase
         end
      end

      for (int i = 0; i < NUM_MOLES; i++) begin
         upNext[i]  = (moleStateNext[i] == MOLE_UP);
         hitNext[i] = (moleStateNext[i] == MOLE_HIT);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tickCnt     <= '0;
         spawnCnt    <= '0;
         lfsr        <= 8'hA5;
         molesUp     <= '0;
         molesHit    <= '0;
         hitPulse    <= 1'b0;
         missPulse   <= 1'b0;
         escapePulse <= 1'b0;
         for (int i = 0; i < NUM_MOLES; i++) begin
            moleState[i] <= MOLE_OFF;
            moleCnt[i]   <= '0;
         end
      end else begin
         tickCnt     <= tickCntNext;
         spawnCnt    <= spawnCntNext;
         lfsr        <= lfsrNext;
         molesUp     <= upNext;
         molesHit    <= hitNext;
         hitPulse    <= hitPulseNext;
         missPulse   <= missPulseNext;
         escapePulse <= escapePulseNext;
         for (int i = 0; i < NUM_MOLES; i++) begin
            moleState[i] <= moleStateNext[i];
            moleCnt[i]   <= moleCntNext[i];
         end
      end
   end

endmodule

// File: tb/tb_mole_scheduler.sv
// Purpose : checks mole_scheduler against a tick-deadline reference model.
// Latency : model updates on each rising edge; outputs compared on the falling edge.
// Backpr. : n/a; two instances (short and long lifetime) share one stimulus stream.
module tb_mole_scheduler;

   localparam int TD = 4;
   localparam int SP = 3;
   localparam int LA = 5;
   localparam int LB = 60;
   localparam int HT = 2;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b0;
   logic       clear = 1'b0;
   logic       whackValid = 1'b0;
   logic [2:0] whackIndex = 3'd0;
   logic [4:0] upA, hitA, upB, hitB;
   logic       hpA, mpA, epA, hpB, mpB, epB;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   mole_scheduler #(.NUM_MOLES(5), .TICK_DIV(TD), .SPAWN_TICKS(SP),
                    .LIFE_TICKS(LA), .HIT_TICKS(HT)) dutA (
      .clock(clock), .reset(reset), .enable(enable), .clear(clear),
      .whackValid(whackValid), .whackIndex(whackIndex),
      .molesUp(upA), .molesHit(hitA),
      .hitPulse(hpA), .missPulse(mpA), .escapePulse(epA));

   mole_scheduler #(.NUM_MOLES(5), .TICK_DIV(TD), .SPAWN_TICKS(SP),
                    .LIFE_TICKS(LB), .HIT_TICKS(HT)) dutB (
      .clock(clock), .reset(reset), .enable(enable), .clear(clear),
      .whackValid(whackValid), .whackIndex(whackIndex),
      .molesUp(upB), .molesHit(hitB),
      .hitPulse(hpB), .missPulse(mpB), .escapePulse(epB));

   // Reference model: moles carry an absolute tick deadline instead of a counter.
   // state codes: 0 off, 1 up, 2 hit.
   logic [7:0]  mLfsr;
   int          mCycles, mTicks;
   int          mState [2][5];
   int          mDead  [2][5];
   logic [12:0] expV   [2];

   always @(posedge clock or negedge reset) begin
      bit tick, spawn, hitP, missP, escP, placed;
      int pre [5];
      int start, m, life, wi;
      if (!reset) begin
         mLfsr   = 8'hA5;
         mCycles = 0;
         mTicks  = 0;
         for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 5; i++) begin
               mState[k][i] = 0;
               mDead[k][i]  = 0;
            end
            expV[k] = '0;
         end
      end else begin
         tick  = 1'b0;
         spawn = 1'b0;
         wi    = int'(whackIndex);
         if (clear) begin
            mCycles = 0;
            mTicks  = 0;
         end else if (enable) begin
            mCycles++;
            tick = ((mCycles % TD) == 0);
            if (tick) mTicks++;
            spawn = tick && ((mTicks % SP) == 0);
         end
         for (int k = 0; k < 2; k++) begin
            hitP = 1'b0; missP = 1'b0; escP = 1'b0;
            life = (k == 0) ? LA : LB;
            if (clear) begin
               for (int i = 0; i < 5; i++) mState[k][i] = 0;
            end else if (enable) begin
               for (int i = 0; i < 5; i++) pre[i] = mState[k][i];
               if (whackValid && wi < 5) begin
                  if (pre[wi] == 1) begin
                     hitP = 1'b1;
                     mState[k][wi] = 2;
                     mDead[k][wi]  = mTicks + HT;
                  end else begin
                     missP = 1'b1;
                  end
               end
               for (int i = 0; i < 5; i++) begin
                  if (tick && mDead[k][i] == mTicks) begin
                     if (pre[i] == 1 && mState[k][i] == 1) begin
                        mState[k][i] = 0;
                        escP = 1'b1;
                     end else if (pre[i] == 2) begin
                        mState[k][i] = 0;
                     end
                  end
               end
               if (spawn) begin
                  start = int'(mLfsr) % 8;
                  if (start >= 5) start -= 5;
                  placed = 1'b0;
                  for (int j = 0; j < 5; j++) begin
                     m = (start + j) % 5;
                     if (!placed && pre[m] == 0) begin
                        mState[k][m] = 1;
                        mDead[k][m]  = mTicks + life;
                        placed = 1'b1;
                     end
                  end
               end
            end
            for (int i = 0; i < 5; i++) begin
               expV[k][8 + i] = (mState[k][i] == 1);
               expV[k][3 + i] = (mState[k][i] == 2);
            end
            expV[k][2:0] = {hitP, missP, escP};
         end
         mLfsr = {mLfsr[6:0], mLfsr[7] ^ mLfsr[5] ^ mLfsr[4] ^ mLfsr[3]};
      end
   end

   function automatic logic [12:0] obs(input int k);
      return (k == 0) ? {upA, hitA, hpA, mpA, epA} : {upB, hitB, hpB, mpB, epB};
   endfunction

   task automatic stepCycle();
      @(posedge clock);
      @(negedge clock);
   endtask

   int firstIdx;

   task automatic test_reset();
      reset = 1'b0; enable = 1'b0; clear = 1'b0; whackValid = 1'b0;
      repeat (3) @(negedge clock);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (obs(k) !== 13'd0) begin
            errors++;
            $display("FAIL reset dut%0d got %h want 0000", k, obs(k));
         end
      end
   endtask

   task automatic test_first_spawn();
      reset  = 1'b1;
      enable = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         stepCycle();
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== expV[k]) begin
               errors++;
               $display("FAIL first_spawn dut%0d cyc%0d got %h want %h", k, c, obs(k), expV[k]);
            end
         end
         if (c == 11) begin
            checks++;
            if (upA !== 5'd0) begin
               errors++;
               $display("FAIL early_spawn got %b want 00000", upA);
            end
         end
      end
      checks++;
      if ($countones(upA) != 1) begin
         errors++;
         $display("FAIL spawn_count got %0d want 1", $countones(upA));
      end
      firstIdx = 0;
      for (int i = 0; i < 5; i++) if (upA[i]) firstIdx = i;
   endtask

   task automatic test_escape();
      int escCount = 0;
      for (int c = 1; c <= 20; c++) begin
         stepCycle();
         if (epA) escCount++;
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== expV[k]) begin
               errors++;
               $display("FAIL escape dut%0d cyc%0d got %h want %h", k, c, obs(k), expV[k]);
            end
         end
      end
      checks++;
      if (escCount != 1 || upA[firstIdx] !== 1'b0) begin
         errors++;
         $display("FAIL escape_once got esc=%0d up=%b want esc=1 bit%0d=0", escCount, upA, firstIdx);
      end
   endtask

   task automatic test_hit();
      int idx = -1;
      for (int c = 0; c < 200 && idx < 0; c++) begin
         for (int i = 4; i >= 0; i--) if (expV[0][8 + i]) idx = i;
         if (idx < 0) stepCycle();
      end
      checks++;
      if (idx < 0) begin
         errors++;
         $display("FAIL hit_wait got no up mole want one within 200 cycles");
         return;
      end
      whackIndex = 3'(idx);
      whackValid = 1'b1;
      stepCycle();
      whackValid = 1'b0;
      checks++;
      if (hpA !== 1'b1 || hitA[idx] !== 1'b1 || upA[idx] !== 1'b0 || obs(0) !== expV[0]) begin
         errors++;
         $display("FAIL hit got %h want %h (slot %0d)", obs(0), expV[0], idx);
      end
      for (int c = 1; c <= 8; c++) begin
         stepCycle();
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== expV[k]) begin
               errors++;
               $display("FAIL hit_hold dut%0d cyc%0d got %h want %h", k, c, obs(k), expV[k]);
            end
         end
      end
      checks++;
      if (hitA[idx] !== 1'b0) begin
         errors++;
         $display("FAIL hit_clear got %b want bit%0d=0", hitA, idx);
      end
   endtask

   task automatic test_miss_invalid();
      int idx = -1;
      for (int i = 4; i >= 0; i--) if (mState[0][i] == 0) idx = i;
      checks++;
      if (idx < 0) begin
         errors++;
         $display("FAIL miss_setup got no off mole want one");
         return;
      end
      whackIndex = 3'(idx);
      whackValid = 1'b1;
      stepCycle();
      checks++;
      if (mpA !== 1'b1 || hpA !== 1'b0 || obs(0) !== expV[0]) begin
         errors++;
         $display("FAIL miss got %h want %h (slot %0d)", obs(0), expV[0], idx);
      end
      whackIndex = 3'd6;
      stepCycle();
      whackValid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (obs(k) !== expV[k] || obs(k) & 13'b110) begin
            errors++;
            $display("FAIL invalid_idx dut%0d got %h want %h", k, obs(k), expV[k]);
         end
      end
   endtask

   task automatic test_full_then_clear();
      int c = 0;
      while (upB !== 5'b11111 && c < 600) begin
         stepCycle();
         c++;
         checks++;
         if (obs(1) !== expV[1]) begin
            errors++;
            $display("FAIL fill dut1 got %h want %h", obs(1), expV[1]);
         end
      end
      checks++;
      if (upB !== 5'b11111) begin
         errors++;
         $display("FAIL fill_timeout got %b want 11111", upB);
      end
      for (int n = 1; n <= 12; n++) begin
         stepCycle();
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== expV[k]) begin
               errors++;
               $display("FAIL full_spawn dut%0d got %h want %h", k, obs(k), expV[k]);
            end
         end
      end
      checks++;
      if (upB !== 5'b11111) begin
         errors++;
         $display("FAIL full_hold got %b want 11111", upB);
      end
      clear = 1'b1; whackValid = 1'b1; whackIndex = 3'd0;
      stepCycle();
      clear = 1'b0; whackValid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (obs(k) !== 13'd0) begin
            errors++;
            $display("FAIL clear dut%0d got %h want 0000", k, obs(k));
         end
      end
      for (int n = 1; n <= 12; n++) begin
         stepCycle();
         if (n == 11) begin
            checks++;
            if (upA !== 5'd0 || upB !== 5'd0) begin
               errors++;
               $display("FAIL clear_counters got %b/%b want 00000", upA, upB);
            end
         end
      end
      checks++;
      if ($countones(upA) != 1 || obs(0) !== expV[0]) begin
         errors++;
         $display("FAIL clear_respawn got %h want %h", obs(0), expV[0]);
      end
   endtask

   task automatic test_freeze();
      logic [12:0] snapA, snapB;
      snapA = {upA, hitA, 3'b000};
      snapB = {upB, hitB, 3'b000};
      enable = 1'b0;
      for (int c = 1; c <= 100; c++) begin
         whackValid = ($urandom_range(0, 2) == 0);
         whackIndex = 3'($urandom_range(0, 7));
         stepCycle();
         checks++;
         if (obs(0) !== snapA || obs(1) !== snapB) begin
            errors++;
            $display("FAIL freeze cyc%0d got %h/%h want %h/%h", c, obs(0), obs(1), snapA, snapB);
         end
      end
      whackValid = 1'b0;
      enable = 1'b1;
   endtask

   task automatic test_hit_on_expiry();
      int idx = -1;
      for (int c = 0; c < 400 && idx < 0; c++) begin
         if (((mCycles + 1) % TD) == 0) begin
            for (int i = 0; i < 5; i++)
               if (mState[0][i] == 1 && mDead[0][i] == mTicks + 1) idx = i;
         end
         if (idx < 0) stepCycle();
      end
      checks++;
      if (idx < 0) begin
         errors++;
         $display("FAIL expiry_wait got no candidate want one within 400 cycles");
         return;
      end
      whackIndex = 3'(idx);
      whackValid = 1'b1;
      stepCycle();
      whackValid = 1'b0;
      checks++;
      if (hpA !== 1'b1 || epA !== 1'b0 || hitA[idx] !== 1'b1 || obs(0) !== expV[0]) begin
         errors++;
         $display("FAIL hit_vs_expiry got %h want %h (slot %0d)", obs(0), expV[0], idx);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 1500; c++) begin
         enable     = ($urandom_range(0, 9) != 0);
         clear      = ($urandom_range(0, 99) == 0);
         whackValid = ($urandom_range(0, 3) == 0);
         whackIndex = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 299) == 0) begin
            reset = 1'b0;
            #1;
            for (int k = 0; k < 2; k++) begin
               checks++;
               if (obs(k) !== 13'd0) begin
                  errors++;
                  $display("FAIL async_reset dut%0d got %h want 0000", k, obs(k));
               end
            end
            @(negedge clock);
            reset = 1'b1;
         end else begin
            stepCycle();
            for (int k = 0; k < 2; k++) begin
               checks++;
               if (obs(k) !== expV[k]) begin
                  errors++;
                  $display("FAIL random dut%0d cyc%0d got %h want %h", k, c, obs(k), expV[k]);
               end
            end
         end
      end
      clear = 1'b0; whackValid = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog got timeout want $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_first_spawn();
      test_escape();
      test_hit();
      test_miss_invalid();
      test_full_then_clear();
      test_freeze();
      test_hit_on_expiry();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mole_scheduler.md
Name: mole_scheduler

Overview:
- Controls when moles appear and disappear for the whack-a-mole game datapath; sits between the main game FSM and the hit-matching/score logic.
- Divides the clock into game ticks and spawns moles at a fixed tick interval, choosing a pseudo-random free slot.
- Tracks each mole's state (OFF / UP / HIT) and its lifetime, and resolves player whacks into hit, miss or escape pulses.

Parameters:
- NUM_MOLES, 5: number of mole slots; fixed at 5, and the index logic is sized for it.
- TICK_DIV, 500000: clock cycles per game tick.
- SPAWN_TICKS, 50: ticks between spawn attempts.
- LIFE_TICKS, 100: ticks a mole stays UP before it escapes.
- HIT_TICKS, 20: ticks a whacked mole is shown in HIT before it returns to OFF.

Ports:
- clock, input, 1: system clock; all state changes on its rising edge.
- reset, input, 1: asynchronous, active-low reset; the block is reset while reset == 0.
- enable, input, 1: high while the game FSM is in INGAME; low freezes all counters and mole states.
- clear, input, 1: synchronous one-cycle pulse from STARTGAME; restarts the round.
- whackValid, input, 1: one-cycle pulse; the player has struck a mole.
- whackIndex, input, 3: mole index struck, valid when whackValid = 1.
- molesUp, output, 5: bit i = 1 when mole i is UP.
- molesHit, output, 5: bit i = 1 when mole i is in HIT.
- hitPulse, output, 1: one cycle; the whack landed on an UP mole.
- missPulse, output, 1: one cycle; the whack landed on a mole that was not UP.
- escapePulse, output, 1: one cycle; at least one UP mole timed out.

Behaviour:
- Reset values:
  - All moles OFF; molesUp = 0, molesHit = 0.
  - All pulse outputs 0.
  - Tick counter, spawn counter and every per-mole counter = 0.
  - LFSR = 8'hA5.
- Output timing: all outputs are registered. An event sampled at rising edge N is visible from edge N onward, for one cycle in the case of pulses.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
  - Advances every clock while reset is deasserted, independent of enable and clear.
- Tick generator:
  - Runs only while enable = 1; counts 0..TICK_DIV-1.
  - Internal tick = 1 on the cycle the counter equals TICK_DIV-1, then the counter wraps to 0.
- Priority per cycle: clear > (enable = 0 freeze) > normal operation.
- clear: forces every mole to OFF, zeroes all counters and suppresses pulses that cycle. Honoured even when enable = 0.
- enable = 0: all counters hold, mole states hold, whacks are ignored, no pulses are generated.
- Per-mole FSM:
  - OFF → UP on spawn; the life counter loads 0.
  - UP → OFF on a tick when the life counter reaches LIFE_TICKS-1 and the mole is not whacked that cycle; this asserts escapePulse.
  - UP → HIT on a whack of this mole; this asserts hitPulse and loads the hit counter with 0.
  - HIT → OFF on a tick when the hit counter reaches HIT_TICKS-1.
  - Counters advance only on ticks.
- Spawn:
  - The spawn counter advances on ticks. When it reaches SPAWN_TICKS-1 on a tick, it wraps to 0 and a spawn attempt occurs that cycle.
  - Start index s = LFSR[2:0]; values 5, 6, 7 map to 0, 1, 2.
  - Probe s, s+1, … s+4 (mod 5) in the same cycle; the first OFF mole becomes UP.
  - If no mole is OFF, the attempt is dropped silently.
- Whack resolution (enable = 1, clear = 0):
  - whackIndex ≤ 4 and that mole UP → hitPulse.
  - whackIndex ≤ 4 and that mole OFF or HIT → missPulse.
  - whackIndex ≥ 5 → ignored, no pulse.
- Simultaneous events:
  - Whack and expiry on the same mole in the same cycle: the hit wins; escapePulse is not asserted for that mole.
  - Whack and spawn targeting the same OFF mole in the same cycle: the whack is judged on the pre-cycle state (missPulse), and the spawn still raises the mole.
  - Several moles expiring on the same tick: a single escapePulse cycle.
- Reset mid-round: the asynchronous reset immediately forces the reset values above; the next round needs no clear.

Test Plan:
Benches use TICK_DIV=4, SPAWN_TICKS=3, LIFE_TICKS=5, HIT_TICKS=2.
- Reset, then enable=1 for 12 cycles → first spawn after 3 ticks (cycle 12); exactly one molesUp bit set, matching the LFSR-derived index.
- Leave that mole untouched → after 5 more ticks (20 cycles) its molesUp bit clears and escapePulse is high for exactly 1 cycle.
- Mole 2 UP, whackValid with whackIndex=2 → next cycle hitPulse=1, molesUp[2]=0, molesHit[2]=1; molesHit[2] clears after 2 ticks.
- whackValid with whackIndex=4 while mole 4 OFF → missPulse=1; whackIndex=6 → no pulse and no state change.
- All 5 moles UP, spawn tick → molesUp stays 5'b11111, no error. Then clear → molesUp=0, molesHit=0, counters zero.
- enable=0 for 100 cycles with a mole UP → molesUp unchanged and no pulses. A whack whose cycle coincides with that mole's final life tick → hitPulse=1 and escapePulse=0.
